// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   DEF_CLKS_PER_BIT = 434;
  localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_done marks the last clock of each bit period while enabled.
// clr forces the count back to 0 so every state starts a fresh bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    bit_done = en && (cnt_q == LAST);
    cnt_d    = cnt_q;
    if (clr || bit_done) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a one-byte holding register; an idle strobe drives the start bit next cycle.
// Optional parity bit between data and stop bits when UART_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter set");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_dat_q, hold_dat_d;
  logic        busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic       bit_done;
  logic       baud_clr;
  logic       baud_en;
  logic       last_stop;
  logic       frame_end;
  logic       load_slot;
  logic       consume;
  logic       accept;
  logic       hold_load;
  logic       new_frame;
  logic [7:0] frame_dat;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (baud_clr),
    .en      (baud_en),
    .bit_done(bit_done)
  );

  // A new frame may be loaded while idle or on the very last stop-bit clock.
  always_comb begin
    last_stop = (STOP_BITS == 1) || stop_idx_q;
    frame_end = (state_q == STOP) && bit_done && last_stop;
    load_slot = (state_q == IDLE) || frame_end;
    consume   = load_slot && hold_vld_q;
    accept    = tx_en && (!hold_vld_q || consume);
    // An empty holding register at a load slot forwards the strobed byte straight into the shifter.
    hold_load = accept && !(load_slot && !hold_vld_q);
    new_frame = load_slot && (hold_vld_q || tx_en);
    frame_dat = hold_vld_q ? hold_dat_q : tx_data;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    hold_vld_d = hold_load | (hold_vld_q & ~consume);
    hold_dat_d = hold_load ? tx_data : hold_dat_q;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE:    if (new_frame) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY:  if (bit_done) state_d = STOP;
`endif
      STOP:    if (frame_end) state_d = new_frame ? START : IDLE;
      default: state_d = IDLE;
    endcase

    if (new_frame) begin
      shift_d   = frame_dat;
      bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
      parity_d  = (^frame_dat) ^ (PARITY_ODD != 0);
`endif
    end

    if ((state_q == DATA) && bit_done) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    if ((state_q == STOP) && bit_done) begin
      stop_idx_d = last_stop ? 1'b0 : ~stop_idx_q;
    end

    busy_d   = (state_d != IDLE) | hold_vld_d;
    baud_clr = (state_d != state_q);
    baud_en  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    tx = IDLE_LEVEL;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
`ifdef UART_PARITY_EN
      PARITY:  tx = parity_q;
`endif
      STOP:    tx = 1'b1;
      default: tx = IDLE_LEVEL;
    endcase
    busy     = busy_q;
    overflow = tx_en & ~accept;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit, one- and two-stop-bit instances.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [7:0] tx_data2;
  logic       tx_en2;
  logic       tx2;
  logic       busy2;
  logic       overflow2;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int ovf_cnt = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_en   (tx_en),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data2),
    .tx_en   (tx_en2),
    .tx      (tx2),
    .busy    (busy2),
    .overflow(overflow2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (overflow) ovf_cnt <= ovf_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next();
  endtask

  task automatic do_reset();
    tx_en  = 1'b0;
    tx_en2 = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks tx on every cycle of one frame; optionally strobes another byte at drv_cyc.
  task automatic frame_check(input string tag, input logic [7:0] b, input int start,
                             input int drv_cyc, input logic [7:0] drv_dat);
    for (int i = 0; i < NB * CPB; i++) begin
      run_to(start + i);
      tx_en = (start + i == drv_cyc);
      if (tx_en) tx_data = drv_dat;
      #1;
      chk(tag, tx, exp_bit(b, i / CPB));
    end
  endtask

  // Samples mid-bit; start < 0 searches (bounded) for the next start bit.
  task automatic decode(input int start, output logic [7:0] d);
    int s;
    int k;
    d = '0;
    if (start < 0) begin
      k = 0;
      while (tx !== 1'b0 && k < 400) begin
        next();
        k++;
      end
      chk("start_found", tx, 1'b0);
      s = cyc;
    end else begin
      s = start;
    end
    for (int i = 0; i < 8; i++) begin
      run_to(s + CPB * (i + 1) + CPB / 2);
      d[i] = tx;
    end
`ifdef UART_PARITY_EN
    run_to(s + CPB * 9 + CPB / 2);
    chk("parity_bit", tx, ^d);
`endif
    run_to(s + CPB * (NB - 1) + CPB / 2);
    chk("stop_bit", tx, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    int         o;
    int         lows;
    int         pre;

    tx_en    = 1'b0;
    tx_data  = 8'h00;
    tx_en2   = 1'b0;
    tx_data2 = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_tx2", tx2, 1'b1);
    chk("rst_busy2", busy2, 1'b0);

    // Single byte 0x55
    do_reset();
    run_to(10);
    tx_data = 8'h55;
    tx_en   = 1'b1;
    #1;
    chk("single_busy_pre", busy, 1'b0);
    chk("single_ovf", overflow, 1'b0);
    frame_check("single_frame", 8'h55, 11, -1, 8'h00);
    chk("single_busy_last", busy, 1'b1);
    run_to(11 + NB * CPB);
    chk("single_busy_end", busy, 1'b0);
    chk("single_tx_end", tx, 1'b1);

    // Back-to-back 0xA5 then 0x3C, no idle gap
    do_reset();
    o = ovf_cnt;
    run_to(10);
    tx_data = 8'hA5;
    tx_en   = 1'b1;
    frame_check("b2b_first", 8'hA5, 11, 20, 8'h3C);
    frame_check("b2b_second", 8'h3C, 11 + NB * CPB, -1, 8'h00);
    run_to(11 + 2 * NB * CPB);
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_no_ovf", ovf_cnt - o, 0);

    // Overflow: third strobe while holding is full
    do_reset();
    o = ovf_cnt;
    run_to(10); tx_data = 8'h01; tx_en = 1'b1;
    run_to(11); tx_en = 1'b0;
    run_to(12); tx_data = 8'h02; tx_en = 1'b1;
    #1;
    chk("ovf_second_ok", overflow, 1'b0);
    run_to(13); tx_en = 1'b0;
    run_to(14); tx_data = 8'h03; tx_en = 1'b1;
    #1;
    chk("ovf_pulse", overflow, 1'b1);
    run_to(15); tx_en = 1'b0;
    #1;
    chk("ovf_pulse_end", overflow, 1'b0);
    decode(11, d);
    chk("ovf_byte1", d, 8'h01);
    decode(-1, d);
    chk("ovf_byte2", d, 8'h02);
    lows = 0;
    repeat (80) begin
      next();
      if (tx === 1'b0) lows++;
    end
    chk("ovf_no_third", lows, 0);
    chk("ovf_count", ovf_cnt - o, 1);
    chk("ovf_busy_end", busy, 1'b0);

    // Reset mid-frame with a byte pending in the holding register
    do_reset();
    run_to(10); tx_data = 8'h00; tx_en = 1'b1;
    run_to(11); tx_en = 1'b0;
    run_to(12); tx_data = 8'h0F; tx_en = 1'b1;
    run_to(13); tx_en = 1'b0;
    run_to(24);
    chk("mid_pre_tx", tx, 1'b0);
    run_to(25);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    do_reset();
    lows = 0;
    repeat (8) begin
      next();
      if (tx === 1'b0 || busy === 1'b1) lows++;
    end
    chk("mid_hold_dropped", lows, 0);
    run_to(10);
    tx_data = 8'hFF;
    tx_en   = 1'b1;
    frame_check("mid_recover", 8'hFF, 11, -1, 8'h00);

    // Two stop bits on the second instance
    do_reset();
    run_to(10); tx_data2 = 8'h5A; tx_en2 = 1'b1;
    run_to(11); tx_en2 = 1'b0;
    pre = 11 + (NB - 1) * CPB;
    run_to(pre - 1);
    chk("stop2_last_bit", tx2, exp_bit(8'h5A, NB - 2));
    for (int i = 0; i < 2 * CPB; i++) begin
      run_to(pre + i);
      chk("stop2_high", tx2, 1'b1);
    end
    chk("stop2_busy_last", busy2, 1'b1);
    run_to(pre + 2 * CPB);
    chk("stop2_busy_end", busy2, 1'b0);
    chk("stop2_tx_end", tx2, 1'b1);

`ifdef UART_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0; 44-cycle frames
    do_reset();
    run_to(10); tx_data = 8'h07; tx_en = 1'b1;
    frame_check("par07_frame", 8'h07, 11, -1, 8'h00);
    run_to(11 + 36);
    chk("par07_bit", tx, 1'b1);
    run_to(11 + 44);
    chk("par07_len", busy, 1'b0);
    do_reset();
    run_to(10); tx_data = 8'h03; tx_en = 1'b1;
    frame_check("par03_frame", 8'h03, 11, -1, 8'h00);
    run_to(11 + 36);
    chk("par03_bit", tx, 1'b0);
    run_to(11 + 43);
    chk("par03_busy_last", busy, 1'b1);
    run_to(11 + 44);
    chk("par03_len", busy, 1'b0);
`endif

    // Periodic source with incrementing byte
    do_reset();
    o = ovf_cnt;
    for (int n = 0; n < 4; n++) begin
      repeat (5) next();
      tx_data = 8'(n);
      tx_en   = 1'b1;
      next();
      tx_en = 1'b0;
      decode(-1, d);
      chk("stream_byte", d, 8'(n));
    end
    chk("stream_no_ovf", ovf_cnt - o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
